// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: line/address types, port select
// and arbiter state encoding.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_pmem_line;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } lc3b_pmem_port_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE_I = 2'd1,
    S_SERVE_D = 2'd2
  } arb_state_t;

  function automatic lc3b_pmem_port_t other_port(input lc3b_pmem_port_t p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cache-side and memory-side line bus seen by the arbiter. The master modport is
// the arbiter's view; slave is the surrounding caches and downstream memory.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  read_out;
  logic                  write_out;
  logic [ADDR_WIDTH-1:0] address_out;
  logic [LINE_WIDTH-1:0] wdata_out;
  logic [LINE_WIDTH-1:0] rdata_in;
  logic                  resp_in;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, rdata_in, resp_in,
    output i_rdata, i_resp, d_rdata, d_resp, read_out, write_out, address_out, wdata_out
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, rdata_in, resp_in,
    input  i_rdata, i_resp, d_rdata, d_resp, read_out, write_out, address_out, wdata_out
  );
endinterface

// File: rtl/pmem_port_mux.sv
// Combinational steering of the granted cache's request onto the memory port
// and of the memory response back to that cache only.
module pmem_port_mux
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  active_i,
  input  lc3b_pmem_port_t       sel_i,
  input  logic                  i_read_i,
  input  logic [ADDR_WIDTH-1:0] i_address_i,
  input  logic                  d_read_i,
  input  logic                  d_write_i,
  input  logic [ADDR_WIDTH-1:0] d_address_i,
  input  logic [LINE_WIDTH-1:0] d_wdata_i,
  input  logic                  resp_i,
  output logic                  read_o,
  output logic                  write_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [LINE_WIDTH-1:0] wdata_o,
  output logic                  i_resp_o,
  output logic                  d_resp_o
);

  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    address_o = '0;
    wdata_o   = '0;
    i_resp_o  = 1'b0;
    d_resp_o  = 1'b0;
    if (active_i) begin
      if (sel_i == PORT_I) begin
        read_o    = i_read_i;
        address_o = i_address_i;
        i_resp_o  = resp_i;
      end else begin
        // a simultaneous read+write from the D-cache is treated as a write
        read_o    = d_read_i & ~d_write_i;
        write_o   = d_write_i;
        address_o = d_address_i;
        wdata_o   = d_wdata_i;
        d_resp_o  = resp_i;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Two-port I/D line arbiter: holds a grant until the memory response, then idles
// one cycle so downstream strobes drop between transactions. Ties go round-robin.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = $bits(lc3b_pmem_addr),
  parameter int LINE_WIDTH = $bits(lc3b_pmem_line)
) (
  input  logic          clk,
  input  logic          reset_n,
  pmem_arbiter_if.master bus
);

  arb_state_t      state_q, state_d;
  lc3b_pmem_port_t last_grant_q, last_grant_d;
  logic            i_pend;
  logic            d_pend;
  logic            grant_active;
  lc3b_pmem_port_t grant_sel;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (i_pend && d_pend) begin
          state_d = (other_port(last_grant_q) == PORT_I) ? S_SERVE_I : S_SERVE_D;
        end else if (i_pend) begin
          state_d = S_SERVE_I;
        end else if (d_pend) begin
          state_d = S_SERVE_D;
        end
      end
      S_SERVE_I: begin
        if (bus.resp_in) begin
          state_d      = S_IDLE;
          last_grant_d = PORT_I;
        end
      end
      S_SERVE_D: begin
        if (bus.resp_in) begin
          state_d      = S_IDLE;
          last_grant_d = PORT_D;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_active = (state_q != S_IDLE);
  assign grant_sel    = (state_q == S_SERVE_D) ? PORT_D : PORT_I;

  // read data is broadcast; only the response is steered
  assign bus.i_rdata = bus.rdata_in;
  assign bus.d_rdata = bus.rdata_in;

  pmem_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_mux (
    .active_i   (grant_active),
    .sel_i      (grant_sel),
    .i_read_i   (bus.i_read),
    .i_address_i(bus.i_address),
    .d_read_i   (bus.d_read),
    .d_write_i  (bus.d_write),
    .d_address_i(bus.d_address),
    .d_wdata_i  (bus.d_wdata),
    .resp_i     (bus.resp_in),
    .read_o     (bus.read_out),
    .write_o    (bus.write_out),
    .address_o  (bus.address_out),
    .wdata_o    (bus.wdata_out),
    .i_resp_o   (bus.i_resp),
    .d_resp_o   (bus.d_resp)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a transaction-level owner model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_pmem_arbiter;

  logic clk;
  logic reset_n;

  pmem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus();

  pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: who currently owns the memory port (-1 none, 0 I, 1 D) and who was served last.
  int m_owner;
  int m_last;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1;
      m_last  <= 1;
    end else if (m_owner < 0) begin
      if (bus.i_read && (bus.d_read || bus.d_write)) m_owner <= (m_last == 1) ? 0 : 1;
      else if (bus.i_read)                          m_owner <= 0;
      else if (bus.d_read || bus.d_write)           m_owner <= 1;
    end else if (bus.resp_in) begin
      m_last  <= m_owner;
      m_owner <= -1;
    end
  end

  logic        log_en = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [15:0] grant_log[$];

  always @(negedge clk) begin
    logic        e_read, e_write, e_iresp, e_dresp;
    logic [15:0]  e_addr;
    logic [127:0] e_wdata;
    e_read = 1'b0; e_write = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
    e_addr = '0;   e_wdata = '0;
    if (m_owner == 0) begin
      e_read  = bus.i_read;
      e_addr  = bus.i_address;
      e_iresp = bus.resp_in;
    end else if (m_owner == 1) begin
      e_write = bus.d_write;
      e_read  = bus.d_read && !bus.d_write;
      e_addr  = bus.d_address;
      e_wdata = bus.d_wdata;
      e_dresp = bus.resp_in;
    end
    chk("mdl_read_out",    bus.read_out,    e_read);
    chk("mdl_write_out",   bus.write_out,   e_write);
    chk("mdl_address_out", bus.address_out, e_addr);
    chk("mdl_wdata_out",   bus.wdata_out,   e_wdata);
    chk("mdl_i_resp",      bus.i_resp,      e_iresp);
    chk("mdl_d_resp",      bus.d_resp,      e_dresp);
    chk("mdl_i_rdata",     bus.i_rdata,     bus.rdata_in);
    chk("mdl_d_rdata",     bus.d_rdata,     bus.rdata_in);
    if (log_en && (bus.read_out || bus.write_out) && !prev_strobe) grant_log.push_back(bus.address_out);
    prev_strobe = bus.read_out || bus.write_out;
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1)
      assert (!(bus.d_read && bus.d_write)) else $error("illegal d_read and d_write together");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    bus.rdata_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic clear_inputs();
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.resp_in = 1'b0;
  endtask

  task automatic do_reset();
    nxt();
    reset_n = 1'b0;
    clear_inputs();
    nxt();
    nxt();
    reset_n = 1'b1;
  endtask

  logic [127:0] wline;
  logic [15:0]  exp_addr;

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    bus.rdata_in = '0;
    wline = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    #2;
    chk("rst_read_out",  bus.read_out,    1'b0);
    chk("rst_write_out", bus.write_out,   1'b0);
    chk("rst_i_resp",    bus.i_resp,      1'b0);
    chk("rst_d_resp",    bus.d_resp,      1'b0);
    chk("rst_address",   bus.address_out, 16'h0);
    chk("rst_wdata",     bus.wdata_out,   128'h0);
    nxt(); nxt();
    reset_n = 1'b1;
    #2 chk("post_rst_read", bus.read_out, 1'b0);

    // single I-cache read: strobe one cycle after request, resp in cycle 4
    nxt(); bus.i_read = 1'b1; bus.i_address = 16'h1230;
    #2 chk("t1_c0_read", bus.read_out, 1'b0);
    nxt();
    #2 chk("t1_c1_read", bus.read_out, 1'b1);
    chk("t1_c1_addr", bus.address_out, 16'h1230);
    nxt(); nxt();
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t1_c4_iresp", bus.i_resp, 1'b1);
    chk("t1_c4_dresp", bus.d_resp, 1'b0);
    nxt(); bus.resp_in = 1'b0; bus.i_read = 1'b0;
    #2 chk("t1_c5_read", bus.read_out, 1'b0);

    // D-cache write with same-cycle ack
    nxt(); bus.d_write = 1'b1; bus.d_address = 16'h4560; bus.d_wdata = wline;
    #2 chk("t2_idle_write", bus.write_out, 1'b0);
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t2_write", bus.write_out, 1'b1);
    chk("t2_dresp", bus.d_resp, 1'b1);
    chk("t2_addr", bus.address_out, 16'h4560);
    chk("t2_wdata", bus.wdata_out, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
    chk("t2_read", bus.read_out, 1'b0);
    nxt(); bus.resp_in = 1'b0; bus.d_write = 1'b0;
    #2 chk("t2_after_write", bus.write_out, 1'b0);
    chk("t2_after_dresp", bus.d_resp, 1'b0);

    // tie from reset: I first, then D after one idle cycle
    do_reset();
    nxt(); bus.i_read = 1'b1; bus.d_read = 1'b1; bus.i_address = 16'h1111; bus.d_address = 16'h2222;
    #2 chk("t3_idle", bus.read_out, 1'b0);
    nxt();
    #2 chk("t3_first_addr", bus.address_out, 16'h1111);
    chk("t3_first_read", bus.read_out, 1'b1);
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t3_iresp", bus.i_resp, 1'b1);
    chk("t3_no_dresp", bus.d_resp, 1'b0);
    nxt(); bus.resp_in = 1'b0; bus.i_read = 1'b0;
    #2 chk("t3_gap", bus.read_out, 1'b0);
    nxt();
    #2 chk("t3_second_addr", bus.address_out, 16'h2222);
    chk("t3_second_read", bus.read_out, 1'b1);
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t3_dresp", bus.d_resp, 1'b1);
    chk("t3_no_iresp", bus.i_resp, 1'b0);
    nxt(); bus.resp_in = 1'b0;
    #2 chk("t3_gap2", bus.read_out, 1'b0);
    bus.i_read = 1'b1;

    // both continuously requesting: last grant was D, so I,D,I,D,I,D
    grant_log.delete();
    log_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_addr = (t % 2 == 0) ? 16'h1111 : 16'h2222;
      nxt();
      #2 chk("t4_grant_addr", bus.address_out, exp_addr);
      chk("t4_grant_read", bus.read_out, 1'b1);
      nxt(); bus.resp_in = 1'b1;
      #2 chk("t4_iresp", bus.i_resp, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("t4_dresp", bus.d_resp, (t % 2 == 0) ? 1'b0 : 1'b1);
      nxt(); bus.resp_in = 1'b0;
      #2 chk("t4_idle_strobes", {bus.read_out, bus.write_out}, 2'b00);
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    log_en = 1'b0;
    chk("t4_log_size", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("t4_log_entry", grant_log[k], (k % 2 == 0) ? 16'h1111 : 16'h2222);

    // asynchronous reset while writing
    nxt(); bus.d_write = 1'b1; bus.d_address = 16'h4560; bus.d_wdata = wline;
    nxt();
    #2 chk("t5_write_before", bus.write_out, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk("t5_write_async", bus.write_out, 1'b0);
    chk("t5_addr_async", bus.address_out, 16'h0);
    chk("t5_wdata_async", bus.wdata_out, 128'h0);
    bus.d_write = 1'b0;
    nxt();
    nxt(); reset_n = 1'b1; bus.i_read = 1'b1; bus.i_address = 16'h0ABC;
    #2 chk("t5_idle", bus.read_out, 1'b0);
    nxt();
    #2 chk("t5_i_grant", bus.read_out, 1'b1);
    chk("t5_i_addr", bus.address_out, 16'h0ABC);
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t5_iresp", bus.i_resp, 1'b1);
    nxt(); bus.resp_in = 1'b0; bus.i_read = 1'b0;

    // stray response while idle is dropped
    nxt(); bus.resp_in = 1'b1;
    #2 chk("t6_iresp", bus.i_resp, 1'b0);
    chk("t6_dresp", bus.d_resp, 1'b0);
    nxt(); bus.resp_in = 1'b0;
    #2 chk("t6_still_idle", {bus.read_out, bus.write_out}, 2'b00);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
